// File: rtl/method_call_arbiter.sv
// Round-robin arbiter sharing one in-order method port among NUM_REQ requesters,
// with a credit limit on calls in flight and a tag FIFO that routes results home.
module method_call_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int RESULT_WIDTH    = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]          req_data_in,
  output logic [NUM_REQ-1:0]                     req_ready_out,
  output logic                                   call_valid_out,
  output logic [DATA_WIDTH-1:0]                  call_data_out,
  input  logic                                   call_valid_in,
  input  logic [RESULT_WIDTH-1:0]                call_result_in,
  output logic [NUM_REQ-1:0]                     rsp_valid_out,
  output logic [RESULT_WIDTH-1:0]                rsp_result_out,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_out,
  output logic                                   error_out
);

  localparam int TW = $clog2(NUM_REQ);
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING+1);

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [TW-1:0] ptr, grant_idx;
  logic [TW:0]   scan;
  logic          grant_hit, can_issue, accept, pop, spurious;
  logic [TW-1:0] tag_mem [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign req_data = req_data_in;

  // A result in this cycle frees its credit immediately.
  assign can_issue = (outstanding_out < CW'(MAX_OUTSTANDING)) || call_valid_in;

  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, ptr} + (TW+1)'(i);
      if (scan >= (TW+1)'(NUM_REQ)) scan = scan - (TW+1)'(NUM_REQ);
      if (!grant_hit && req_valid_in[scan[TW-1:0]]) begin
        grant_hit = 1'b1;
        grant_idx = scan[TW-1:0];
      end
    end
  end

  // Ready is gated by rst so the handshake reads idle while reset is held.
  assign accept        = grant_hit && can_issue && !rst;
  assign req_ready_out = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign pop           = call_valid_in && (outstanding_out != '0);
  assign spurious      = call_valid_in && (outstanding_out == '0) && !accept;

  always_ff @(posedge clk)
    if (accept) tag_mem[wr_ptr] <= grant_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr             <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      outstanding_out <= '0;
      call_valid_out  <= 1'b0;
      call_data_out   <= '0;
      rsp_valid_out   <= '0;
      rsp_result_out  <= '0;
      error_out       <= 1'b0;
    end else begin
      call_valid_out <= accept;
      if (accept) begin
        ptr           <= (grant_idx == TW'(NUM_REQ-1)) ? '0 : grant_idx + TW'(1);
        wr_ptr        <= wr_ptr + AW'(1);
        call_data_out <= req_data[grant_idx];
      end
      rsp_valid_out <= pop ? (NUM_REQ'(1) << tag_mem[rd_ptr]) : '0;
      if (pop) begin
        rd_ptr         <= rd_ptr + AW'(1);
        rsp_result_out <= call_result_in;
      end
      case ({accept, pop})
        2'b10:   outstanding_out <= outstanding_out + CW'(1);
        2'b01:   outstanding_out <= outstanding_out - CW'(1);
        default: outstanding_out <= outstanding_out;
      endcase
      if (spurious) error_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_method_call_arbiter.sv
// Randomized scoreboard bench for method_call_arbiter: a driver issues requests and
// predicts grants/credits, a negedge monitor checks calls and routed responses.
module tb_method_call_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 32;
  localparam int MO = 8;
  localparam int CW = $clog2(MO+1);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid_in;
  logic [N*DW-1:0]   req_data_in;
  logic [N-1:0]      req_ready_out;
  logic              call_valid_out;
  logic [DW-1:0]     call_data_out;
  logic              call_valid_in;
  logic [RW-1:0]     call_result_in;
  logic [N-1:0]      rsp_valid_out;
  logic [RW-1:0]     rsp_result_out;
  logic [CW-1:0]     outstanding_out;
  logic              error_out;

  method_call_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst), .req_valid_in(req_valid_in), .req_data_in(req_data_in),
    .req_ready_out(req_ready_out), .call_valid_out(call_valid_out), .call_data_out(call_data_out),
    .call_valid_in(call_valid_in), .call_result_in(call_result_in), .rsp_valid_out(rsp_valid_out),
    .rsp_result_out(rsp_result_out), .outstanding_out(outstanding_out), .error_out(error_out));

  always #5 clk = ~clk;

  typedef struct {int due; logic [DW-1:0] data;} call_t;
  typedef struct {int due; int req; logic [RW-1:0] val;} rsp_t;

  call_t call_q[$];   // calls expected on the method port
  call_t res_q[$];    // results the method model will return
  rsp_t  acc_q[$];    // accepted calls awaiting their result
  rsp_t  rsp_q[$];    // responses expected on rsp_*

  int tests = 0, fails = 0, cyc = 0;
  int mptr = 0, mcount = 0, last_due = 0;
  bit merr = 0;
  bit [N-1:0] en = '0, pend = '0;
  int seq [N];
  int lim [N];
  logic [DW-1:0] pdata [N];
  int lat_min = 3, lat_max = 3;
  bit rnd_mode = 0, spur_now = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus plus the reference model of grant, credit and error.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    int g;
    bit can, pop;
    call_t c;
    rsp_t r;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && en[i] && (lim[i] < 0 || seq[i] < lim[i]) &&
          (!rnd_mode || $urandom_range(1, 0) == 1)) begin
        pend[i]  = 1'b1;
        pdata[i] = rnd_mode ? DW'($urandom) : DW'(i*100 + seq[i]);
      end
      req_valid_in[i]         = pend[i];
      req_data_in[i*DW +: DW] = pdata[i];
    end
    call_valid_in = 1'b0;
    if (spur_now) begin
      call_valid_in  = 1'b1;
      call_result_in = 32'hDEAD;
      spur_now       = 1'b0;
    end else if (res_q.size() > 0 && res_q[0].due <= cyc) begin
      c              = res_q.pop_front();
      call_valid_in  = 1'b1;
      call_result_in = c.data;
    end
    #3;
    chk("outstanding", outstanding_out, mcount);
    chk("error", error_out, merr);
    can = (mcount < MO) || call_valid_in;
    g = -1;
    if (can)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (g < 0 && pend[j]) g = j;
      end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("ready", req_ready_out, exp_rdy);
    pop = call_valid_in && mcount > 0;
    if (pop) begin
      r = acc_q.pop_front();
      r.due = cyc + 1;
      rsp_q.push_back(r);
    end
    if (call_valid_in && mcount == 0 && g < 0) merr = 1'b1;
    if (g >= 0) begin
      c.due = cyc + 1; c.data = pdata[g];
      call_q.push_back(c);
      r.due = 0; r.req = g; r.val = pdata[g] + 4;
      acc_q.push_back(r);
      mptr = (g + 1) % N;
      pend[g] = 1'b0;
      seq[g]++;
    end
    mcount = mcount + (g >= 0 ? 1 : 0) - (pop ? 1 : 0);
  endtask

  task automatic drain();
    int n = 0;
    en = '0;
    while ((call_q.size() > 0 || acc_q.size() > 0 || rsp_q.size() > 0 ||
            res_q.size() > 0 || mcount != 0 || pend != '0) && n < 300) begin
      cycle();
      n++;
    end
    chk("drain_timeout", n < 300, 1);
  endtask

  task automatic run_until(input int r, input int target);
    int n = 0;
    while (seq[r] < target && n < 200) begin
      cycle();
      n++;
    end
    chk("accept_timeout", n < 200, 1);
  endtask

  // Monitor: checks method calls and responses, and plays the method (result = arg+4).
  always @(negedge clk) begin
    if (!rst) begin
      bit ec, er;
      call_t c, m;
      rsp_t r;
      int due;
      ec = call_q.size() > 0 && call_q[0].due == cyc;
      chk("call_valid", call_valid_out, ec);
      if (ec) begin
        c = call_q.pop_front();
        chk("call_data", call_data_out, c.data);
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        m.due = due; m.data = call_data_out + 4;
        res_q.push_back(m);
      end
      er = rsp_q.size() > 0 && rsp_q[0].due == cyc;
      if (er) begin
        r = rsp_q.pop_front();
        chk("rsp_valid", rsp_valid_out, N'(1) << r.req);
        chk("rsp_result", rsp_result_out, r.val);
      end else begin
        chk("rsp_idle", rsp_valid_out, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin seq[i] = 0; lim[i] = -1; pdata[i] = '0; end
    rst = 1'b1; req_valid_in = '1; req_data_in = '1;
    call_valid_in = 1'b0; call_result_in = '0;
    #12;
    chk("rst_ready", req_ready_out, 0);
    chk("rst_call_valid", call_valid_out, 0);
    chk("rst_call_data", call_data_out, 0);
    chk("rst_rsp_valid", rsp_valid_out, 0);
    chk("rst_rsp_result", rsp_result_out, 0);
    chk("rst_outstanding", outstanding_out, 0);
    chk("rst_error", error_out, 0);
    req_valid_in = '0;
    @(posedge clk); #3 rst = 1'b0;

    // single requester 0, data 0..9, latency 3
    lat_min = 3; lat_max = 3;
    en = 4'b0001; lim[0] = 10;
    run_until(0, 10);
    drain();

    // all requesters continuously valid, latency 2
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < N; i++) lim[i] = -1;
    en = 4'b1111;
    repeat (40) cycle();
    drain();

    // credit limit with long latency on requester 1
    lat_min = 20; lat_max = 20;
    en = 4'b0010;
    repeat (50) cycle();
    drain();

    // spurious result, then normal traffic with sticky error
    spur_now = 1'b1;
    cycle();
    lat_min = 3; lat_max = 3;
    en = 4'b0010; lim[1] = seq[1] + 5;
    run_until(1, lim[1]);
    drain();

    // randomized traffic and latency
    rnd_mode = 1'b1; lat_min = 1; lat_max = 6;
    for (int i = 0; i < N; i++) lim[i] = -1;
    en = 4'b1111;
    repeat (200) cycle();
    drain();
    rnd_mode = 1'b0;

    // asynchronous reset with 5 calls in flight
    lat_min = 20; lat_max = 20;
    en = 4'b0001; lim[0] = seq[0] + 5;
    run_until(0, lim[0]);
    repeat (2) cycle();
    en = '0;
    @(negedge clk); #2;
    req_valid_in = '1;
    rst = 1'b1;
    #1;
    chk("arst_ready", req_ready_out, 0);
    chk("arst_call_valid", call_valid_out, 0);
    chk("arst_call_data", call_data_out, 0);
    chk("arst_rsp_valid", rsp_valid_out, 0);
    chk("arst_rsp_result", rsp_result_out, 0);
    chk("arst_outstanding", outstanding_out, 0);
    chk("arst_error", error_out, 0);
    req_valid_in = '0;
    call_q.delete(); res_q.delete(); acc_q.delete(); rsp_q.delete();
    mptr = 0; mcount = 0; merr = 1'b0; pend = '0; last_due = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("post_rst_outstanding", outstanding_out, 0);

    // first post-reset request from requester 2, leaves ptr at 3
    lat_min = 3; lat_max = 3;
    en = 4'b0100; lim[2] = seq[2] + 1;
    run_until(2, lim[2]);
    drain();

    // requesters 0 and 3 valid with ptr=3: 3 then 0
    lim[0] = seq[0] + 1; lim[3] = seq[3] + 1;
    en = 4'b1001;
    repeat (3) cycle();
    chk("ptr3_both_served", (seq[0] == lim[0]) && (seq[3] == lim[3]), 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
